mem_port_arbiter: RTL and testbench

- Shares one single-port data/instruction RAM between two requesters: the fetch stage (instruction reads) and the memory stage (LDR/STR data accesses driven by mem_w_en and the ALU-computed address).
- Memory-stage accesses have priority, and a starvation counter bounds fetch delay.
- Drives stall_pc back to the fetch/PC logic while a fetch is outstanding.
- Sits between the pipeline stages and the RAM macro.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_starve_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and widths for the single-port RAM arbiter
//            (FSM states, requester identity, counter widths).
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    IF = 1'b0,
    DM = 1'b1
  } arb_owner_t;

  // Holds RD_LAT-1 for RD_LAT up to 7
  localparam int LAT_W    = 3;
  // Holds STARVE_MAX up to 15
  localparam int STARVE_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_starve_ctr
// Purpose  : Counts consecutive memory-stage wins taken while a fetch is
//            waiting; at_max tells the arbiter to hand the next slot to fetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  import mem_arb_pkg::*;

  logic [STARVE_W-1:0] cnt;

  assign at_max = (cnt == STARVE_W'(STARVE_MAX));

  // Clear has priority; the count never runs past STARVE_MAX
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port RAM between the fetch stage and the
//            memory stage. Memory-stage accesses win ties, bounded by a
//            starvation counter; stall_pc holds the PC while a fetch waits.
//            Optional performance counters: define MEM_PORT_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,   // 1..7
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
`ifdef MEM_PORT_ARB_PERF_EN
  input  logic              perf_clr,
  output logic [15:0]       perf_if_stall,
  output logic [15:0]       perf_dm_txn,
`endif
  output logic              stall_pc
);
  import mem_arb_pkg::*;

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_owner_t       owner;
  logic [LAT_W-1:0] lat_cnt;
  logic             we_q;
  logic             if_win;
  logic             dm_win;
  logic             starve_inc;
  logic             starve_clr;
  logic             at_max;
  logic             issue;
  logic             rdone;

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  // Arbitration: only evaluated in IDLE; fetch wins when alone or starved
  always_comb begin
    if_win     = 1'b0;
    dm_win     = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    if (state == IDLE) begin
      if (if_req && (!dm_req || at_max)) begin
        if_win = 1'b1;
      end else if (dm_req) begin
        dm_win = 1'b1;
      end
      starve_inc = if_req && dm_req && !at_max;
      starve_clr = if_win || !if_req;
    end
  end

  // Next-state: stores return straight to IDLE, loads wait out the RAM latency
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_win || dm_win) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? IDLE : WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, capture of the winning request, and read-latency countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= IF;
      lat_cnt   <= '0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (if_win) begin
        owner    <= IF;
        we_q     <= 1'b0;
        mem_addr <= if_addr;
      end else if (dm_win) begin
        owner     <= DM;
        we_q      <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(RD_LAT - 1);
      end else if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  assign issue     = (state == ISSUE);
  assign rdone     = (state == WAIT) && (lat_cnt == '0);
  assign mem_en    = issue;
  assign mem_we    = issue && we_q;
  assign if_gnt    = issue && (owner == IF);
  assign dm_gnt    = issue && (owner == DM);
  assign if_rvalid = rdone && (owner == IF);
  assign dm_rvalid = rdone && (owner == DM);
  // Read data is only driven while its valid strobe is up
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : 32'd0;
  assign stall_pc  = if_req && !if_rvalid;

`ifdef MEM_PORT_ARB_PERF_EN
  // Saturating event counters for fetch stall cycles and data grants
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_if_stall <= 16'd0;
      perf_dm_txn   <= 16'd0;
    end else begin
      if (stall_pc && perf_if_stall != 16'hFFFF) perf_if_stall <= perf_if_stall + 16'd1;
      if (dm_gnt && perf_dm_txn != 16'hFFFF) perf_dm_txn <= perf_dm_txn + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed bench for mem_port_arbiter. Two instances (RD_LAT=1 and
//            RD_LAT=3) are checked every cycle against a transaction-timeline
//            model, plus literal expectations for the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int STARVE_MAX = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst       [2];
  logic              if_req    [2];
  logic [ADDR_W-1:0] if_addr   [2];
  logic              if_gnt    [2];
  logic              if_rvalid [2];
  logic [31:0]       if_rdata  [2];
  logic              dm_req    [2];
  logic              dm_we     [2];
  logic [ADDR_W-1:0] dm_addr   [2];
  logic [31:0]       dm_wdata  [2];
  logic              dm_gnt    [2];
  logic              dm_rvalid [2];
  logic [31:0]       dm_rdata  [2];
  logic              mem_en    [2];
  logic              mem_we    [2];
  logic [ADDR_W-1:0] mem_addr  [2];
  logic [31:0]       mem_wdata [2];
  logic [31:0]       mem_rdata [2];
  logic              stall_pc  [2];
`ifdef MEM_PORT_ARB_PERF_EN
  logic              perf_clr      [2];
  logic [15:0]       perf_if_stall [2];
  logic [15:0]       perf_dm_txn   [2];
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(1), .STARVE_MAX(STARVE_MAX)) u_lat1 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]), .dm_rdata(dm_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
`ifdef MEM_PORT_ARB_PERF_EN
    .perf_clr(perf_clr[0]), .perf_if_stall(perf_if_stall[0]), .perf_dm_txn(perf_dm_txn[0]),
`endif
    .stall_pc(stall_pc[0])
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(3), .STARVE_MAX(STARVE_MAX)) u_lat3 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]), .dm_rdata(dm_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
`ifdef MEM_PORT_ARB_PERF_EN
    .perf_clr(perf_clr[1]), .perf_if_stall(perf_if_stall[1]), .perf_dm_txn(perf_dm_txn[1]),
`endif
    .stall_pc(stall_pc[1])
  );

  // Model: one pending transaction per instance, described by the cycles
  // at which its grant, read data and return to idle must appear.
  bit          m_busy   [2];
  bit          m_own    [2];   // 0 = fetch, 1 = data
  bit          m_we     [2];
  logic [7:0]  m_addr   [2];
  logic [31:0] m_wdata  [2];
  int          m_iss    [2];
  int          m_rv     [2];   // -1 for stores
  int          m_end    [2];
  int          m_starve [2];

  bit if_gs   [2];
  bit dm_gs   [2];
  bit if_hold [2];
  bit dm_hold [2];

  int    cyc;
  int    n_chk;
  int    n_fail;
  bit    chk_en;
  string order;
  int    ng;
  int    guard;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk1(string name, int k, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, k, cyc, act, exp);
    end
  endtask

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit idle;
      bit e_en;
      bit e_rv;
      bit w_if;
      bit w_dm;
      idle = !m_busy[k] || (cyc >= m_end[k]);
      e_en = !idle && (cyc == m_iss[k]);
      e_rv = !idle && (m_rv[k] >= 0) && (cyc == m_rv[k]);
      if (chk_en) begin
        chk1("mem_en",    k, mem_en[k],    e_en);
        chk1("mem_we",    k, mem_we[k],    e_en && m_we[k]);
        chk1("if_gnt",    k, if_gnt[k],    e_en && !m_own[k]);
        chk1("dm_gnt",    k, dm_gnt[k],    e_en && m_own[k]);
        chk1("if_rvalid", k, if_rvalid[k], e_rv && !m_own[k]);
        chk1("dm_rvalid", k, dm_rvalid[k], e_rv && m_own[k]);
        chk1("stall_pc",  k, stall_pc[k],  if_req[k] && !(e_rv && !m_own[k]));
        if (e_en) chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_addr[k]));
        if (e_en && m_we[k]) chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
        if (e_rv && !m_own[k]) chk("if_rdata", k, if_rdata[k], mem_rdata[k]);
        if (e_rv && m_own[k]) chk("dm_rdata", k, dm_rdata[k], mem_rdata[k]);
      end
      if_gs[k] = (if_gnt[k] === 1'b1);
      dm_gs[k] = (dm_gnt[k] === 1'b1);
      // Advance using the inputs that the coming edge samples
      if (rst[k]) begin
        m_busy[k]   = 1'b0;
        m_starve[k] = 0;
      end else if (idle) begin
        m_busy[k] = 1'b0;
        w_if = if_req[k] && (!dm_req[k] || m_starve[k] >= STARVE_MAX);
        w_dm = dm_req[k] && !w_if;
        if (if_req[k] && dm_req[k] && m_starve[k] < STARVE_MAX) m_starve[k]++;
        else if (w_if || !if_req[k]) m_starve[k] = 0;
        if (w_if || w_dm) begin
          m_busy[k]  = 1'b1;
          m_own[k]   = w_dm;
          m_we[k]    = w_dm && dm_we[k];
          m_addr[k]  = w_dm ? dm_addr[k] : if_addr[k];
          m_wdata[k] = dm_wdata[k];
          m_iss[k]   = cyc + 1;
          if (m_we[k]) begin
            m_rv[k]  = -1;
            m_end[k] = cyc + 2;
          end else begin
            m_rv[k]  = cyc + 1 + lat_of(k);
            m_end[k] = cyc + 2 + lat_of(k);
          end
        end
      end
    end
  endtask

  // Check the current cycle, cross the edge, then let requesters drop req
  // on the cycle after they saw their grant.
  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (if_gs[k] && !if_hold[k]) if_req[k] = 1'b0;
      if (dm_gs[k] && !dm_hold[k]) dm_req[k] = 1'b0;
    end
    #1;
  endtask

  function automatic bit sig(int k, int w);
    case (w)
      0:       return if_gnt[k] === 1'b1;
      1:       return if_rvalid[k] === 1'b1;
      2:       return dm_gnt[k] === 1'b1;
      3:       return dm_rvalid[k] === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(int k, int w, string name);
    int n;
    n = 0;
    while (!sig(k, w) && n < 50) begin
      tick();
      n++;
    end
    n_chk++;
    if (!sig(k, w)) begin
      n_fail++;
      $display("FAIL %s dut%0d: still low after %0d cycles, expected a pulse", name, k, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;       if_req[k] = 1'b0;   if_addr[k] = '0;
      dm_req[k] = 1'b0;    dm_we[k] = 1'b0;    dm_addr[k] = '0;
      dm_wdata[k] = '0;    mem_rdata[k] = '0;  if_hold[k] = 1'b0;
      dm_hold[k] = 1'b0;   m_busy[k] = 1'b0;   m_starve[k] = 0;
`ifdef MEM_PORT_ARB_PERF_EN
      perf_clr[k] = 1'b0;
`endif
    end
    cyc = 0; n_chk = 0; n_fail = 0; chk_en = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;

    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk1("rst_mem_en", k, mem_en[k], 1'b0);
      chk1("rst_if_gnt", k, if_gnt[k], 1'b0);
      chk1("rst_dm_gnt", k, dm_gnt[k], 1'b0);
      chk1("rst_dm_rvalid", k, dm_rvalid[k], 1'b0);
      chk("rst_mem_addr", k, 32'(mem_addr[k]), 32'h0);
      chk("rst_mem_wdata", k, mem_wdata[k], 32'h0);
    end
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (4) tick();

    // Fetch only, RD_LAT=1
    mem_rdata[0] = 32'hE3A01005;
    if_addr[0] = 8'h10;
    if_req[0] = 1'b1;
    #1;
    chk1("t1_stall_n", 0, stall_pc[0], 1'b1);
    tick();
    chk1("t1_if_gnt", 0, if_gnt[0], 1'b1);
    chk1("t1_mem_en", 0, mem_en[0], 1'b1);
    chk("t1_mem_addr", 0, 32'(mem_addr[0]), 32'h10);
    chk1("t1_mem_we", 0, mem_we[0], 1'b0);
    chk1("t1_stall_n1", 0, stall_pc[0], 1'b1);
    tick();
    chk1("t1_if_rvalid", 0, if_rvalid[0], 1'b1);
    chk("t1_if_rdata", 0, if_rdata[0], 32'hE3A01005);
    chk1("t1_stall_n2", 0, stall_pc[0], 1'b0);
    tick();
    chk1("t1_rvalid_once", 0, if_rvalid[0], 1'b0);
    repeat (2) tick();

    // Store, then a fetch raised during ISSUE is served from the next IDLE
    dm_we[0] = 1'b1;
    dm_addr[0] = 8'h20;
    dm_wdata[0] = 32'hDEADBEEF;
    dm_req[0] = 1'b1;
    tick();
    chk1("t2_dm_gnt", 0, dm_gnt[0], 1'b1);
    chk1("t2_mem_en", 0, mem_en[0], 1'b1);
    chk1("t2_mem_we", 0, mem_we[0], 1'b1);
    chk("t2_mem_addr", 0, 32'(mem_addr[0]), 32'h20);
    chk("t2_mem_wdata", 0, mem_wdata[0], 32'hDEADBEEF);
    if_addr[0] = 8'h44;
    if_req[0] = 1'b1;
    tick();
    chk1("t2_no_dm_rvalid", 0, dm_rvalid[0], 1'b0);
    chk1("t2_idle_no_en", 0, mem_en[0], 1'b0);
    tick();
    chk1("t2_fetch_gnt", 0, if_gnt[0], 1'b1);
    chk("t2_fetch_addr", 0, 32'(mem_addr[0]), 32'h44);
    wait_sig(0, 1, "t2_fetch_rvalid");
    tick();
    repeat (3) tick();

    // Both requesters held continuously: starvation bound
    dm_we[0] = 1'b0;
    dm_addr[0] = 8'h30;
    if_addr[0] = 8'h31;
    if_hold[0] = 1'b1;
    dm_hold[0] = 1'b1;
    if_req[0] = 1'b1;
    dm_req[0] = 1'b1;
    order = "";
    ng = 0;
    guard = 0;
    while (ng < 10 && guard < 200) begin
      tick();
      guard++;
      if (if_gnt[0] === 1'b1) begin
        order = {order, "I"};
        ng++;
      end else if (dm_gnt[0] === 1'b1) begin
        order = {order, "D"};
        ng++;
      end
    end
    if_hold[0] = 1'b0;
    dm_hold[0] = 1'b0;
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    n_chk++;
    if (order != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL t3_grant_order dut0: got %s expected DDDDIDDDDI", order);
    end
    repeat (6) tick();

    // RD_LAT=3 load; fetch raised at N+2 waits for the load to finish
    mem_rdata[1] = 32'h12345678;
    dm_we[1] = 1'b0;
    dm_addr[1] = 8'h05;
    dm_req[1] = 1'b1;
    tick();
    chk1("t4_dm_gnt", 1, dm_gnt[1], 1'b1);
    chk1("t4_mem_en", 1, mem_en[1], 1'b1);
    chk("t4_mem_addr", 1, 32'(mem_addr[1]), 32'h05);
    tick();
    if_addr[1] = 8'h33;
    if_req[1] = 1'b1;
    chk1("t4_rvalid_n2", 1, dm_rvalid[1], 1'b0);
    tick();
    chk1("t4_rvalid_n3", 1, dm_rvalid[1], 1'b0);
    tick();
    chk1("t4_rvalid_n4", 1, dm_rvalid[1], 1'b1);
    chk("t4_dm_rdata", 1, dm_rdata[1], 32'h12345678);
    tick();
    chk1("t4_if_gnt_n5", 1, if_gnt[1], 1'b0);
    tick();
    chk1("t4_if_gnt_n6", 1, if_gnt[1], 1'b1);
    chk("t4_if_addr", 1, 32'(mem_addr[1]), 32'h33);
    wait_sig(1, 1, "t4_if_rvalid");
    tick();
    repeat (2) tick();

    // Reset during WAIT discards the read
    dm_we[1] = 1'b0;
    dm_addr[1] = 8'h06;
    dm_wdata[1] = 32'hA5A5A5A5;
    dm_req[1] = 1'b1;
    tick();
    chk1("t5_dm_gnt", 1, dm_gnt[1], 1'b1);
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk1("t5_mem_en", 1, mem_en[1], 1'b0);
    chk1("t5_mem_we", 1, mem_we[1], 1'b0);
    chk1("t5_if_gnt", 1, if_gnt[1], 1'b0);
    chk1("t5_dm_gnt0", 1, dm_gnt[1], 1'b0);
    chk1("t5_if_rvalid", 1, if_rvalid[1], 1'b0);
    chk1("t5_dm_rvalid", 1, dm_rvalid[1], 1'b0);
    chk("t5_mem_addr", 1, 32'(mem_addr[1]), 32'h0);
    chk("t5_mem_wdata", 1, mem_wdata[1], 32'h0);
    chk("t5_dm_rdata", 1, dm_rdata[1], 32'h0);
    chk("t5_if_rdata", 1, if_rdata[1], 32'h0);
    chk1("t5_stall", 1, stall_pc[1], 1'b0);
    if_addr[1] = 8'h7C;
    if_req[1] = 1'b1;
    tick();
    chk1("t5_fetch_gnt", 1, if_gnt[1], 1'b1);
    chk("t5_fetch_addr", 1, 32'(mem_addr[1]), 32'h7C);
    chk1("t5_stale_rvalid", 1, dm_rvalid[1], 1'b0);
    tick();
    chk1("t5_dm_rvalid_n5", 1, dm_rvalid[1], 1'b0);
    tick();
    chk1("t5_if_rvalid_n6", 1, if_rvalid[1], 1'b0);
    tick();
    chk1("t5_if_rvalid_n7", 1, if_rvalid[1], 1'b1);
    chk("t5_if_rdata_n7", 1, if_rdata[1], 32'h12345678);
    repeat (3) tick();

`ifdef MEM_PORT_ARB_PERF_EN
    // Performance counters: 5 fetches (2 stall cycles each) and 3 stores
    perf_clr[0] = 1'b1;
    tick();
    perf_clr[0] = 1'b0;
    chk("t6_clr_stall", 0, 32'(perf_if_stall[0]), 32'd0);
    chk("t6_clr_txn", 0, 32'(perf_dm_txn[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if_addr[0] = 8'(8'h50 + i);
      if_req[0] = 1'b1;
      wait_sig(0, 1, "t6_fetch_rvalid");
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      dm_we[0] = 1'b1;
      dm_addr[0] = 8'(8'h60 + i);
      dm_wdata[0] = 32'hC0DE0000 + i;
      dm_req[0] = 1'b1;
      wait_sig(0, 2, "t6_store_gnt");
      tick();
    end
    tick();
    chk("t6_perf_if_stall", 0, 32'(perf_if_stall[0]), 32'd10);
    chk("t6_perf_dm_txn", 0, 32'(perf_dm_txn[0]), 32'd3);
    perf_clr[0] = 1'b1;
    tick();
    perf_clr[0] = 1'b0;
    chk("t6_reclr_stall", 0, 32'(perf_if_stall[0]), 32'd0);
    chk("t6_reclr_txn", 0, 32'(perf_dm_txn[0]), 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
